// File: rtl/prime_buf.sv
// prime_buf: requests primes from a generator one at a time and
// buffers them in a small first-word-fall-through FIFO.
module prime_buf #(
    parameter int WIDTH_LOG = 4,
    parameter int DEPTH_LOG = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    output logic                        pg_go,
    input  logic                        pg_ready,
    input  logic                        pg_error,
    input  logic [(1<<WIDTH_LOG)-1:0]   pg_res,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [(1<<WIDTH_LOG)-1:0]   out_data,
    output logic [DEPTH_LOG:0]          count,
    output logic                        full,
    output logic                        error,
    output logic [(1<<WIDTH_LOG)-1:0]   nprimes
);

    localparam int WIDTH = 1 << WIDTH_LOG;
    localparam int DEPTH = 1 << DEPTH_LOG;

    localparam logic [DEPTH_LOG:0]   DEPTH_C = DEPTH[DEPTH_LOG:0];
    localparam logic [DEPTH_LOG:0]   CNT_ONE = {{DEPTH_LOG{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG-1:0] PTR_ONE = {{(DEPTH_LOG-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]     NP_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_ERR
    } state_e;

    state_e               state_q, state_d;
    logic                 first_q, first_d;
    logic                 go_q;
    logic                 err_q, err_d;
    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [DEPTH_LOG-1:0] rptr_q, wptr_q;
    logic [DEPTH_LOG:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]     np_q;
    logic                 push;
    logic                 pop;

    assign pop       = out_valid && out_ready;
    assign out_valid = (cnt_q != '0);
    assign out_data  = mem_q[rptr_q];
    assign count     = cnt_q;
    assign full      = (cnt_q == DEPTH_C);
    assign error     = err_q;
    assign nprimes   = np_q;
    assign pg_go     = go_q;

    // Controller next state; a slot is reserved when leaving IDLE.
    always_comb begin
        state_d = state_q;
        first_d = 1'b0;
        err_d   = err_q;
        push    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en && pg_ready && (cnt_q < DEPTH_C)) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
                first_d = 1'b1;
            end
            S_WAIT: begin
                // Generator ready is stale for one cycle after go.
                if (!first_q && pg_ready) begin
                    if (pg_error) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Occupancy follows push/pop; a simultaneous pair cancels.
    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (!push && pop) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    // Control, pointer and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            first_q <= 1'b0;
            go_q    <= 1'b0;
            err_q   <= 1'b0;
            rptr_q  <= '0;
            wptr_q  <= '0;
            cnt_q   <= '0;
            np_q    <= '0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            go_q    <= (state_d == S_REQ);
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            if (push) begin
                wptr_q <= wptr_q + PTR_ONE;
                if (np_q != '1) begin
                    np_q <= np_q + NP_ONE;
                end
            end
            if (pop) begin
                rptr_q <= rptr_q + PTR_ONE;
            end
        end
    end

    // FIFO storage, intentionally left without reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= pg_res;
        end
    end

endmodule

// File: tb/tb_prime_buf.sv
// tb_prime_buf: prime_buf against a behavioural prime generator
// and a next-prime scoreboard.
module tb_prime_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        pg_go;
    logic        pg_ready;
    logic        pg_error;
    logic [15:0] pg_res;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [2:0]  count;
    logic        full;
    logic        error;
    logic [15:0] nprimes;

    prime_buf #(.WIDTH_LOG(4), .DEPTH_LOG(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .pg_go     (pg_go),
        .pg_ready  (pg_ready),
        .pg_error  (pg_error),
        .pg_res    (pg_res),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .full      (full),
        .error     (error),
        .nprimes   (nprimes)
    );

    always #5 clk = ~clk;

    function automatic bit is_prime(int n);
        if (n < 2) return 1'b0;
        for (int d = 2; d * d <= n; d++) begin
            if (n % d == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int nextp(int p);
        for (int c = p + 1; c < 70000; c++) begin
            if (is_prime(c)) return c;
        end
        return 0;
    endfunction

    // Generator model: ready falls one cycle after go is sampled,
    // then rises after a random latency with the next prime.
    logic        gen_rst;
    logic [15:0] g_res;
    logic        g_ready;
    logic        g_err;
    logic        g_pend;
    int          g_lat;
    int          g_reqs;
    int          err_at;
    int          lat_min;
    int          lat_max;

    assign pg_res   = g_res;
    assign pg_ready = g_ready;
    assign pg_error = g_err;

    always @(posedge clk) begin
        if (gen_rst) begin
            g_res   <= 16'd1;
            g_ready <= 1'b1;
            g_err   <= 1'b0;
            g_pend  <= 1'b0;
            g_lat   <= 0;
            g_reqs  <= 0;
        end else begin
            if (pg_go) begin
                g_pend <= 1'b1;
                g_reqs <= g_reqs + 1;
            end
            if (g_pend) begin
                g_pend  <= 1'b0;
                g_ready <= 1'b0;
                g_lat   <= int'($urandom_range(lat_max, lat_min));
            end else if (!g_ready) begin
                if (g_lat == 0) begin
                    g_ready <= 1'b1;
                    if (g_reqs == err_at) g_err <= 1'b1;
                    else g_res <= 16'(nextp(int'(g_res)));
                end else begin
                    g_lat <= g_lat - 1;
                end
            end
        end
    end

    int checks = 0;
    int errors = 0;
    int last;
    int npops;
    int ngo;
    int max_cnt;
    logic go_prev;
    logic en_prev;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic mon();
        int e;
        if (pg_go) chk("go_one_cycle", 32'(go_prev), 0);
        if (pg_go && !go_prev) begin
            ngo++;
            chk("go_needs_en", 32'(en_prev), 1);
        end
        chk("full_vs_count", 32'(full), 32'(count == 3'd4));
        chk("valid_vs_count", 32'(out_valid), 32'(count != 3'd0));
        if (int'(count) > max_cnt) max_cnt = int'(count);
        if (out_valid && out_ready) begin
            e = nextp(last);
            chk("pop_data", 32'(out_data), 32'(e));
            last = e;
            npops++;
        end
        go_prev = pg_go;
        en_prev = en;
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        gen_rst   = 1'b1;
        en        = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b1;
        gen_rst = 1'b0;
        last    = 1;
        npops   = 0;
        ngo     = 0;
        max_cnt = 0;
        go_prev = 1'b0;
        en_prev = 1'b0;
    endtask

    typedef struct {
        int npop;
        int head;
        int np;
    } drain_t;

    drain_t tbl [5];

    initial begin
        int k;
        int g0;
        int fresh;
        tbl[0] = '{1, 3, 5};
        tbl[1] = '{1, 5, 6};
        tbl[2] = '{2, 11, 8};
        tbl[3] = '{3, 19, 11};
        tbl[4] = '{4, 37, 15};
        err_at    = 0;
        lat_min   = 0;
        lat_max   = 3;
        rst       = 1'b1;
        gen_rst   = 1'b1;
        en        = 1'b0;
        out_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rst_go", 32'(pg_go), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_nprimes", 32'(nprimes), 0);

        // Fill
        do_reset();
        en = 1'b1;
        for (k = 0; k < 300 && !full; k++) tick();
        chk("fill_full", 32'(full), 1);
        repeat (20) tick();
        chk("fill_count", 32'(count), 4);
        chk("fill_nprimes", 32'(nprimes), 4);
        chk("fill_ngo", 32'(ngo), 4);
        chk("fill_head", 32'(out_data), 2);

        // Drain steps from the table
        for (int i = 0; i < 5; i++) begin
            out_ready = 1'b1;
            repeat (tbl[i].npop) tick();
            out_ready = 1'b0;
            for (k = 0; k < 300 && !full; k++) tick();
            repeat (10) tick();
            chk("drain_count", 32'(count), 4);
            chk("drain_head", 32'(out_data), 32'(tbl[i].head));
            chk("drain_nprimes", 32'(nprimes), 32'(tbl[i].np));
        end

        // Stream
        do_reset();
        lat_min   = 0;
        lat_max   = 4;
        en        = 1'b1;
        out_ready = 1'b1;
        for (k = 0; k < 600 && npops < 10; k++) tick();
        chk("stream_pops", 32'(npops), 10);
        chk("stream_last", 32'(last), 29);
        chk("stream_maxcnt_le1", 32'(max_cnt <= 1), 1);

        // Generator error on third request
        do_reset();
        err_at = 3;
        en     = 1'b1;
        for (k = 0; k < 300 && !error; k++) tick();
        chk("err_flag", 32'(error), 1);
        g0 = ngo;
        repeat (20) tick();
        chk("err_ngo", 32'(ngo), 3);
        chk("err_no_more_go", 32'(ngo), 32'(g0));
        chk("err_count", 32'(count), 2);
        chk("err_nprimes", 32'(nprimes), 2);
        out_ready = 1'b1;
        repeat (6) tick();
        chk("err_drained", 32'(npops), 2);
        chk("err_valid", 32'(out_valid), 0);
        chk("err_sticky", 32'(error), 1);
        err_at = 0;

        // Reset while waiting on the third request
        do_reset();
        lat_min = 12;
        lat_max = 12;
        en      = 1'b1;
        for (k = 0; k < 300 && nprimes != 16'd2; k++) tick();
        for (k = 0; k < 50 && !pg_go; k++) tick();
        chk("rw_go_seen", 32'(pg_go), 1);
        repeat (3) tick();
        chk("rw_cnt_pre", 32'(count), 2);
        fresh = nextp(nextp(int'(g_res)));
        #2 rst = 1'b0;
        #1;
        chk("rw_count", 32'(count), 0);
        chk("rw_valid", 32'(out_valid), 0);
        chk("rw_go", 32'(pg_go), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        for (k = 0; k < 300 && !out_valid; k++) tick();
        chk("rw_fresh", 32'(out_data), 32'(fresh));
        chk("rw_nprimes", 32'(nprimes), 1);

        // en drops one cycle after go
        do_reset();
        lat_min   = 1;
        lat_max   = 4;
        en        = 1'b1;
        out_ready = 1'b1;
        for (k = 0; k < 50 && !pg_go; k++) tick();
        chk("en_go_seen", 32'(pg_go), 1);
        tick();
        en = 1'b0;
        repeat (30) tick();
        chk("en_pushed", 32'(nprimes), 1);
        chk("en_popped", 32'(npops), 1);
        chk("en_ngo", 32'(ngo), 1);

        // Random traffic
        do_reset();
        lat_min = 0;
        lat_max = 6;
        for (int i = 0; i < 2000; i++) begin
            en        = ($urandom % 4) != 0;
            out_ready = ($urandom % 2) != 0;
            tick();
        end
        en        = 1'b0;
        out_ready = 1'b0;
        repeat (40) tick();
        chk("rand_conserve", 32'(nprimes), 32'(npops + int'(count)));
        chk("rand_maxcnt_le4", 32'(max_cnt <= 4), 1);
        chk("rand_some_pops", 32'(npops > 20), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prime_buf.md
PRIME_BUF -- requirements
Module: prime_buf

Interface
REQ-001 The block SHALL have parameter WIDTH_LOG, default 4, which sets the prime width WIDTH = 1 << WIDTH_LOG, matching the generator.
REQ-002 The block SHALL have parameter DEPTH_LOG, default 2, which sets the FIFO depth DEPTH = 1 << DEPTH_LOG entries.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset, with these two ports listed first:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port en  input  1  level enable; while high, the block requests new primes.
REQ-005 The block SHALL have port pg_go  output  1  go pulse to the prime generator.
REQ-006 The block SHALL have port pg_ready  input  1  ready flag from the prime generator.
REQ-007 The block SHALL have port pg_error  input  1  error (overflow) flag from the prime generator.
REQ-008 The block SHALL have port pg_res  input  WIDTH  current prime from the generator.
REQ-009 The block SHALL have port out_valid  output  1  FIFO not empty.
REQ-010 The block SHALL have port out_ready  input  1  consumer accepts out_data.
REQ-011 The block SHALL have port out_data  output  WIDTH  FIFO head entry.
REQ-012 The block SHALL have port count  output  DEPTH_LOG+1  current FIFO occupancy.
REQ-013 The block SHALL have port full  output  1  count == DEPTH.
REQ-014 The block SHALL have port error  output  1  generator overflow latched.
REQ-015 The block SHALL have port nprimes  output  WIDTH  number of primes pushed, saturating at all-ones.

Function
REQ-016 The controller SHALL have exactly 4 states:
- IDLE: waiting for en and FIFO space.
- REQ: pg_go is asserted.
- WAIT: waiting for the generator result.
- ERR: terminal error state.
REQ-017 IDLE SHALL go to REQ when en==1, pg_ready==1 and count < DEPTH; otherwise IDLE SHALL stay in IDLE.
REQ-018 pg_go SHALL be registered and equal 1 only while in REQ, so each request is exactly one cycle; REQ SHALL always go to WAIT on the next cycle.
REQ-019 WAIT SHALL ignore pg_ready in its first cycle and SHALL thereafter wait for pg_ready==1, because the generator's ready drops one cycle after go is sampled.
REQ-020 In WAIT, on pg_ready==1 with pg_error==0, the block SHALL push pg_res into the FIFO in that same clock edge and SHALL go to IDLE.
REQ-021 In WAIT, on pg_ready==1 with pg_error==1, the block SHALL make no push, SHALL go to ERR and SHALL set error=1.
REQ-022 ERR SHALL be left only by reset; in ERR, pg_go SHALL stay 0, error SHALL stay 1, and the FIFO SHALL keep draining normally.
REQ-023 The power-on generator value (res=1, ready=1 before any go) SHALL never be pushed; only results that complete a request issued by this block SHALL be pushed.
REQ-024 At most one request SHALL be outstanding at a time, so a push always has space reserved at REQ time and an overflow push SHALL be impossible.
REQ-025 The FIFO SHALL be a register array of DEPTH x WIDTH with read and write pointers of DEPTH_LOG bits that wrap modulo DEPTH.
REQ-026 out_valid SHALL equal (count != 0), and out_data SHALL be the entry at the read pointer with zero-latency first-word-fall-through.
REQ-027 A pop SHALL occur when out_valid && out_ready; a pop while empty SHALL be ignored with no pointer or count change.
REQ-028 On a simultaneous push and pop, both pointers SHALL advance and count SHALL be unchanged; this SHALL be legal at count==DEPTH when the push was reserved before the pop.
REQ-029 nprimes SHALL increment by 1 per push and SHALL hold at 2^WIDTH-1 once it reaches that value.
REQ-030 If en is deasserted during REQ or WAIT, the outstanding request SHALL still complete and push; the block SHALL then stay in IDLE.
REQ-031 full SHALL be driven combinationally from count.

Reset
REQ-032 On rst low, the block SHALL immediately (asynchronously) set state=IDLE, pg_go=0, read pointer=0, write pointer=0, count=0, full=0, out_valid=0, error=0 and nprimes=0.
REQ-033 FIFO data registers SHALL not be reset, and out_data SHALL be don't-care while out_valid==0.
REQ-034 A reset asserted mid-request SHALL abandon that request; after release, the block SHALL wait in IDLE until pg_ready==1 before issuing the next request.
REQ-035 Release of rst SHALL be synchronous to clk; the first state transition SHALL occur no earlier than the first rising edge after release.

Verification
REQ-036 Fill: instance with a real generator, en=1, out_ready=0 -> FIFO holds 2,3,5,7; full=1; count=4; pg_go stays 0 afterwards; nprimes=4.
REQ-037 Drain: after the fill, out_ready=1 for 1 cycle -> 2 is popped; next request is issued; the FIFO later holds 3,5,7,11 and nprimes=5.
REQ-038 Stream: out_ready=1 throughout, run 10 primes -> output sequence 2,3,5,7,11,13,17,19,23,29; every pg_go pulse is 1 cycle wide; count never exceeds 1.
REQ-039 Error: generator model returns pg_error=1 on the 3rd request -> 2 and 3 are pushed; error=1; state ERR; no further pg_go; FIFO drains 2,3 then out_valid=0.
REQ-040 Reset mid-WAIT with count=2 -> count=0, out_valid=0, pg_go=0 in the same cycle as the reset; after release, the first pushed value comes from a fresh request.
REQ-041 en toggle: en drops one cycle after pg_go -> the pending prime is still pushed and no further pg_go is issued while en==0.
